// File: rtl/imem_loader.sv
// Program-load sequencer: streams instruction words into imem and
// holds the core in reset until the program is fully written.
module imem_loader #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t          state, state_nx;
    logic [ADDR_W:0] ptr;
    logic [CW-1:0]   hold_cnt;
    logic            accept;
    logic            at_end;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid & in_ready;
    assign at_end   = (ptr == (ADDR_W + 1)'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: if (accept && (in_last || at_end)) state_nx = HOLD;
            HOLD: if (hold_cnt == '0) state_nx = RUN;
            RUN:  if (start) state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_addr  <= ptr[ADDR_W-1:0];
                imem_wdata <= in_data;
                ptr        <= ptr + 1'b1;
            end
            if ((state == IDLE || state == RUN) && start) ptr <= '0;
            // in_last wins over the full-memory case on the final slot
            if (accept && in_last) begin
                word_count <= ptr + 1'b1;
                overflow   <= 1'b0;
            end else if (accept && at_end) begin
                word_count <= (ADDR_W + 1)'(DEPTH);
                overflow   <= 1'b1;
            end
            if (state == LOAD && state_nx == HOLD)
                hold_cnt <= CW'(HOLD_CYCLES);
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
            core_reset <= (state_nx != RUN);
            done       <= (state_nx == RUN);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes, counts and
// release timing come from a simple list model of the program.
module tb_imem_loader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int HOLD   = 2;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_last;
    logic [31:0]       in_data;
    logic              in_ready, imem_we, core_reset, done, overflow;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done),
        .word_count(word_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int fall_cyc = -1;
    logic rst_prev = 1'b1;
    logic [37:0] wq[$];
    logic [31:0] words[$];

    logic [31:0] prog [18] = '{
        32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025,
        32'h00642824, 32'h00a42820, 32'h10a7000a, 32'h0064202a,
        32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
        32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011,
        32'h20020001, 32'hac020054
    };

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write seen on the port, and when the core is released
    always @(negedge clk) begin
        if (imem_we) begin
            wq.push_back({imem_addr, imem_wdata});
            check("we_core_rst", 64'(core_reset), 64'd1);
        end
        if (rst_prev && !core_reset) fall_cyc = cyc;
        rst_prev = core_reset;
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_rdy"}, 64'(in_ready), 64'd0);
        check({pfx, "_we"}, 64'(imem_we), 64'd0);
        check({pfx, "_addr"}, 64'(imem_addr), 64'd0);
        check({pfx, "_wdata"}, 64'(imem_wdata), 64'd0);
        check({pfx, "_crst"}, 64'(core_reset), 64'd1);
        check({pfx, "_done"}, 64'(done), 64'd0);
        check({pfx, "_wc"}, 64'(word_count), 64'd0);
        check({pfx, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_rdy", 64'(in_ready), 64'd1);
        check("start_crst", 64'(core_reset), 64'd1);
        check("start_done", 64'(done), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drive(input int n, input bit use_last, input int gap,
                         input bit noise, input int exp_n);
        int i = 0;
        int acc_n = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 2000) begin
            in_data  = words[i];
            in_last  = use_last && (i == n - 1);
            in_valid = (acc_n >= exp_n) ? 1'b1 : ($urandom_range(99) >= gap);
            start    = noise && ($urandom_range(3) == 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc_n >= exp_n) check("ign_rdy", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            if (acc) begin
                acc_n++;
                last_acc = cyc;
            end
            if (acc || acc_n >= exp_n) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        check("drv_budget", 64'(guard < 2000), 64'd1);
        check("acc_count", 64'(acc_n), 64'(exp_n));
    endtask

    task automatic wait_run(input bit hold_noise);
        int k = 0;
        start = hold_noise;
        @(negedge clk);
        check("rdy_after", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("run_reached", 64'(done), 64'd1);
        check("run_crst", 64'(core_reset), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic check_writes(input int exp_n);
        check("n_writes", 64'(wq.size()), 64'(exp_n));
        for (int i = 0; i < exp_n && i < wq.size(); i++)
            check("write", 64'(wq[i]), {26'd0, 6'(i), words[i]});
    endtask

    task automatic run_load(input int n, input bit use_last, input int gap,
                            input bit noise);
        int exp_n;
        exp_n = (n < DEPTH) ? n : DEPTH;
        wq.delete();
        fall_cyc = -1;
        do_start();
        drive(n, use_last, gap, noise, exp_n);
        wait_run(noise && use_last);
        check_writes(exp_n);
        check("word_count", 64'(word_count), 64'(exp_n));
        check("overflow", 64'(overflow), 64'(!use_last));
        check("release_lat", 64'(fall_cyc - last_acc), 64'(1 + HOLD));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;

        words.delete();
        for (int i = 0; i < 18; i++) words.push_back(prog[i]);
        run_load(18, 1'b1, 0, 1'b0);

        fill_random(4);
        run_load(4, 1'b1, 0, 1'b0);
        fill_random(2);
        run_load(2, 1'b1, 0, 1'b0);

        fill_random(20);
        run_load(20, 1'b1, 60, 1'b1);

        fill_random(70);
        run_load(70, 1'b0, 0, 1'b0);

        fill_random(DEPTH);
        run_load(DEPTH, 1'b1, 30, 1'b0);

        fill_random(1);
        run_load(1, 1'b1, 0, 1'b1);

        // Reset in the middle of a load
        fill_random(8);
        wq.delete();
        do_start();
        drive(5, 1'b0, 40, 1'b0, 5);
        reset = 1'b1; in_valid = 1'b1; in_data = words[5];
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        check_writes(5);
        @(posedge clk); #1;
        fill_random(3);
        run_load(3, 1'b1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 40);
            fill_random(n);
            run_load(n, 1'b1, $urandom_range(0, 70), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program-load sequencer that drives the instruction-memory write port of the single-cycle MIPS core and owns the core's reset. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses. While loading it holds the core in reset, then releases the core so execution starts at PC 0. It is the stimulus end of the core's memory interface: the testbench and store-checker watch memwrite/dataadr/writedata, and this block supplies the program that produces them.

## Interface
Parameters:
- DEPTH, 64, instruction-memory size in words; power of two.
- ADDR_W, 6, word-address width; log2(DEPTH).
- HOLD_CYCLES, 2, cycles core_reset stays high after the last write; must be >= 1.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- start  input  1  one-cycle request to begin a load.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_data  input  32  instruction word.
- in_last  input  1  marks the final word of the program.
- in_ready  output  1  block can accept a word this cycle.
- imem_we  output  1  instruction-memory write enable, registered.
- imem_addr  output  ADDR_W  word address for the write, registered.
- imem_wdata  output  32  write data, registered.
- core_reset  output  1  reset to the MIPS core, active-high, registered.
- done  output  1  high while the core is running a loaded program.
- word_count  output  ADDR_W+1  number of words in the last completed load.
- overflow  output  1  last load was truncated at DEPTH words.

## Operation
- A word is accepted in a cycle when in_valid & in_ready are both high.
- States: IDLE, LOAD, HOLD, RUN.
- IDLE:
  - core_reset=1, in_ready=0, done=0.
  - start -> LOAD; write pointer cleared to 0.
- LOAD:
  - in_ready=1.
  - Each accept issues one registered write: imem_addr=ptr, imem_wdata=in_data. Then ptr increments.
  - If the accepted word has in_last=1: go to HOLD. word_count=ptr+1, overflow=0.
  - If the accepted word is at ptr==DEPTH-1 with in_last=0: go to HOLD. word_count=DEPTH, overflow=1. Later in_valid is ignored because in_ready=0.
  - start is ignored in LOAD.
- HOLD:
  - in_ready=0, core_reset=1.
  - A down-counter loaded with HOLD_CYCLES runs; at zero -> RUN.
  - start is ignored.
- RUN:
  - core_reset=0, done=1, in_ready=0.
  - start -> LOAD with ptr=0. core_reset=1 and done=0 from the next cycle.
  - word_count and overflow hold until the next load completes.
- Address never wraps. ptr has ADDR_W+1 bits; its maximum used value is DEPTH-1.
- reset in any state:
  - next state IDLE.
  - Any in-flight write is dropped: imem_we=0 on the next cycle.
  - All counters cleared.
- Reset value of every output: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, word_count=0, overflow=0.

## Timing
- start seen in IDLE at edge n: in_ready=1 from cycle n+1.
- Word accepted at edge k: imem_we=1 with that addr/data during cycle k+1, for exactly one cycle per accepted word.
- Back-to-back accepts give a continuous write burst. A gap in in_valid gives a gap in imem_we.
- Last word accepted at edge k:
  - in_ready=0 in cycle k+1.
  - core_reset falls at edge k+1+HOLD_CYCLES, and done rises at the same edge.
  - The final write (cycle k+1) always completes while core_reset is still high.
- Transition from RUN on start at edge m: core_reset=1 and in_ready=1 in cycle m+1.
- in_ready depends only on registered state, with no combinational path from in_valid. in_data must be stable only in the accept cycle.

## Test plan
- Nominal load of the 18-word MIPS test program, in_valid held high, in_last on word 18:
  - imem_we pulses at addr 0..17 with matching data.
  - word_count=18, overflow=0.
  - core_reset falls 1+HOLD_CYCLES cycles after the last accept.
  - The core then stores 7 to address 84.
- Backpressure and gaps, in_valid toggling 1,0,0,1,...: writes land only on accept cycles, addresses stay contiguous, and no duplicate or skipped address occurs.
- Overflow, DEPTH=64 with 70 words sent and no in_last:
  - Exactly 64 writes occur (addr 0..63).
  - in_ready drops after the 64th accept.
  - word_count=64, overflow=1.
  - Words 65..70 have no effect.
- reset asserted in LOAD after word 5: the next cycle shows the IDLE state and every output at its reset value, with no write in that cycle. A new start reloads from addr 0.
- Reload from RUN:
  - Load 4 words, reach RUN, pulse start: core_reset=1 on the next cycle.
  - Load 2 words: word_count=2 and core_reset is released again.
- start pulsed during LOAD and HOLD: no effect on ptr, state, or timing.
